// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
// Includes the state and grant encodings plus the legal READ_LAT range check.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR,
    RESP
  } state_e;

  typedef enum logic {
    GNT_IF,
    GNT_DM
  } grant_e;

  localparam int unsigned BYTE_OFF = 2;

  function automatic bit read_lat_ok(input int unsigned lat);
    return (lat >= 1) && (lat <= 4);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-way arbiter between fetch and data channels.
// When both channels request, priority alternates based on the last grant.
module mem_arbiter
  import mem_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   if_req,
  input  logic   dm_req,
  input  logic   enable,
  output grant_e grant,
  output logic   grant_valid
);

  grant_e last_q;

  always_comb begin
    if (if_req && dm_req) begin
      grant = (last_q == GNT_DM) ? GNT_IF : GNT_DM;
    end else if (dm_req) begin
      grant = GNT_DM;
    end else begin
      grant = GNT_IF;
    end
    grant_valid = enable && (if_req || dm_req);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= GNT_IF;
    end else if (grant_valid) begin
      last_q <= grant;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-side initiator for the multicycle core: arbitrates fetch and data
// requests, drives Adr/WD/WE, waits out read latency and acks each channel.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [31:0]           dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_ack,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  misalign,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] Adr,
  output logic [DATA_WIDTH-1:0] WD,
  output logic                  WE,
  input  logic [DATA_WIDTH-1:0] RD
);

  if (!read_lat_ok(READ_LAT)) begin : g_read_lat_check
    $error("mem_access_ctrl: READ_LAT must be in 1..4");
  end

  localparam logic [2:0] LAT_INIT = 3'(READ_LAT);

  state_e state, state_nxt;
  grant_e grant, gnt_q, gnt_nxt;
  logic   grant_valid;
  logic   mis_q, mis_nxt;
  logic [2:0] cnt, cnt_nxt;

  logic [ADDR_WIDTH-1:0] adr_nxt;
  logic [DATA_WIDTH-1:0] wd_nxt, if_rdata_nxt, dm_rdata_nxt;
  logic we_nxt, if_ack_nxt, dm_ack_nxt, misalign_nxt, busy_nxt;

  logic [31:0] sel_addr;
  logic        sel_we, sel_mis;
  logic        unused_addr_bits;

  mem_arbiter u_arb (
    .clk         (clk),
    .reset       (reset),
    .if_req      (if_req),
    .dm_req      (dm_req),
    .enable      (state == IDLE),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign sel_addr = (grant == GNT_DM) ? dm_addr : if_addr;
  assign sel_we   = (grant == GNT_DM) && dm_we;
  assign sel_mis  = (sel_addr[BYTE_OFF-1:0] != '0);
  // Upper address bits are dropped on purpose: the word address wraps.
  assign unused_addr_bits = ^sel_addr[31:ADDR_WIDTH+BYTE_OFF];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      gnt_q    <= GNT_IF;
      mis_q    <= 1'b0;
      cnt      <= '0;
      Adr      <= '0;
      WD       <= '0;
      WE       <= 1'b0;
      if_ack   <= 1'b0;
      dm_ack   <= 1'b0;
      misalign <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt_q    <= gnt_nxt;
      mis_q    <= mis_nxt;
      cnt      <= cnt_nxt;
      Adr      <= adr_nxt;
      WD       <= wd_nxt;
      WE       <= we_nxt;
      if_ack   <= if_ack_nxt;
      dm_ack   <= dm_ack_nxt;
      misalign <= misalign_nxt;
      if_rdata <= if_rdata_nxt;
      dm_rdata <= dm_rdata_nxt;
      busy     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          if (sel_mis)     state_nxt = RESP;
          else if (sel_we) state_nxt = WR;
          else             state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: if (cnt == 3'd1) state_nxt = RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are computed as next-cycle values so every port comes from a flop.
  always_comb begin
    gnt_nxt      = gnt_q;
    mis_nxt      = mis_q;
    cnt_nxt      = cnt;
    adr_nxt      = Adr;
    wd_nxt       = WD;
    if_rdata_nxt = if_rdata;
    dm_rdata_nxt = dm_rdata;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          gnt_nxt = grant;
          mis_nxt = sel_mis;
          if (!sel_mis) begin
            adr_nxt = sel_addr[ADDR_WIDTH+BYTE_OFF-1:BYTE_OFF];
            if (sel_we) wd_nxt  = dm_wdata;
            else        cnt_nxt = LAT_INIT;
          end
        end
      end
      RD_WAIT: begin
        cnt_nxt = cnt - 3'd1;
        if (cnt == 3'd1) begin
          if (gnt_q == GNT_DM) dm_rdata_nxt = RD;
          else                 if_rdata_nxt = RD;
        end
      end
      default: ;
    endcase
    we_nxt       = (state_nxt == WR);
    if_ack_nxt   = (state_nxt == RESP) && (gnt_nxt == GNT_IF);
    dm_ack_nxt   = (state_nxt == RESP) && (gnt_nxt == GNT_DM);
    misalign_nxt = (state_nxt == RESP) && mis_nxt;
    busy_nxt     = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: one instance at READ_LAT=1 with a
// writable memory model, one at READ_LAT=3 for latency and address wrap.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_ack, dm_ack, misalign, busy, WE;
  logic [31:0] if_rdata, dm_rdata, WD, RD;
  logic [7:0]  Adr;

  logic        if_req3, dm_req3, dm_we3;
  logic [31:0] if_addr3, dm_addr3, dm_wdata3;
  logic        if_ack3, dm_ack3, misalign3, busy3, WE3;
  logic [31:0] if_rdata3, dm_rdata3, WD3, RD3;
  logic [7:0]  Adr3;

  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [7:0]  a3_d1, a3_d2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          dm;
    logic [31:0] data;
    bit          mis;
  } exp_t;

  exp_t sb1[$];
  exp_t sb3[$];
  exp_t e1, e3;

  mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LAT(1)) dut (
    .clk(clk), .reset(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .misalign(misalign), .busy(busy),
    .Adr(Adr), .WD(WD), .WE(WE), .RD(RD)
  );

  mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LAT(3)) dut3 (
    .clk(clk), .reset(rst_n),
    .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_rdata(if_rdata3),
    .dm_req(dm_req3), .dm_we(dm_we3), .dm_addr(dm_addr3), .dm_wdata(dm_wdata3),
    .dm_ack(dm_ack3), .dm_rdata(dm_rdata3), .misalign(misalign3), .busy(busy3),
    .Adr(Adr3), .WD(WD3), .WE(WE3), .RD(RD3)
  );

  // Memory models: READ_LAT=1 reads through directly, READ_LAT=3 via two stages.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem1[3] <= 32'h20080005;
      mem3[1] <= 32'hCAFE0001;
    end else if (WE) begin
      mem1[Adr] <= WD;
    end
    a3_d1 <= Adr3;
    a3_d2 <= a3_d1;
  end
  assign RD  = mem1[Adr];
  assign RD3 = mem3[a3_d2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (if_ack || dm_ack) begin
        if (sb1.size() == 0) begin
          chk("unexpected_ack", {30'b0, dm_ack, if_ack}, 32'd0);
        end else begin
          e1 = sb1.pop_front();
          chk("ack_channel", {30'b0, dm_ack, if_ack}, e1.dm ? 32'd2 : 32'd1);
          chk("ack_rdata", e1.dm ? dm_rdata : if_rdata, e1.data);
          chk("ack_misalign", 32'(misalign), 32'(e1.mis));
        end
      end else if (misalign) begin
        chk("stray_misalign", 32'(misalign), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (dm_ack3 || misalign3 || WE3) begin
        chk("dut3_stray_output", {29'b0, WE3, misalign3, dm_ack3}, 32'd0);
      end
      if (if_ack3) begin
        if (sb3.size() == 0) begin
          chk("dut3_unexpected_ack", 32'(if_ack3), 32'd0);
        end else begin
          e3 = sb3.pop_front();
          chk("dut3_ack_rdata", if_rdata3, e3.data);
        end
      end
    end
  end

  task automatic xfer(input bit dm, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input int exp_lat,
                      input logic [7:0] exp_adr, input bit chk_adr,
                      input int exp_we, input string name);
    int cyc = 0;
    int wecnt = 0;
    bit acked = 1'b0;
    if (dm) begin
      dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    while (!acked && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (WE) begin
        wecnt++;
        chk({name, "_we_adr"}, 32'(Adr), 32'(exp_adr));
      end
      if (cyc == 1) begin
        chk({name, "_c1_busy"}, 32'(busy), 32'd1);
        if (chk_adr) chk({name, "_c1_adr"}, 32'(Adr), 32'(exp_adr));
      end
      acked = dm ? dm_ack : if_ack;
    end
    dm_req = 1'b0;
    if_req = 1'b0;
    chk({name, "_latency"}, cyc, exp_lat);
    chk({name, "_we_cycles"}, wecnt, exp_we);
    @(negedge clk);
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    if_req3 = 1'b0; dm_req3 = 1'b0; dm_we3 = 1'b0;
    if_addr3 = '0; dm_addr3 = '0; dm_wdata3 = '0;
    repeat (2) @(negedge clk);
    chk("rst_adr", 32'(Adr), 32'd0);
    chk("rst_we_busy_ack", {28'b0, WE, busy, if_ack, dm_ack}, 32'd0);
    chk("rst_wd", WD, 32'd0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    sb1.push_back('{dm: 1'b0, data: 32'h20080005, mis: 1'b0});
    xfer(1'b0, 1'b0, 32'h0000000C, 32'h0, 2, 8'h03, 1'b1, 0, "fetch");

    sb1.push_back('{dm: 1'b1, data: 32'h0, mis: 1'b0});
    xfer(1'b1, 1'b1, 32'h00000040, 32'hDEADBEEF, 2, 8'h10, 1'b1, 1, "store");
    chk("store_wd", WD, 32'hDEADBEEF);

    sb1.push_back('{dm: 1'b1, data: 32'hDEADBEEF, mis: 1'b0});
    xfer(1'b1, 1'b0, 32'h00000040, 32'h0, 2, 8'h10, 1'b1, 0, "load");
    chk("load_if_rdata_kept", if_rdata, 32'h20080005);

    sb1.push_back('{dm: 1'b1, data: 32'hDEADBEEF, mis: 1'b1});
    xfer(1'b1, 1'b0, 32'h00000042, 32'h0, 1, 8'h10, 1'b1, 0, "misalign");
    chk("misalign_dm_rdata_kept", dm_rdata, 32'hDEADBEEF);

    sb1.push_back('{dm: 1'b0, data: 32'h20080005, mis: 1'b0});
    xfer(1'b0, 1'b0, 32'h0000000C, 32'h0, 2, 8'h03, 1'b1, 0, "fetch2");

    // Contention: last grant was fetch, so data goes first, then alternate.
    for (int n = 0; n < 4; n++) begin
      sb1.push_back('{dm: (n % 2 == 0), data: (n % 2 == 0) ? 32'hDEADBEEF : 32'h20080005, mis: 1'b0});
    end
    if_addr = 32'h0C; dm_addr = 32'h40; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    for (int n = 0; n < 4; n++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!(if_ack || dm_ack) && cyc < 20);
      chk("contention_grant", {30'b0, dm_ack, if_ack}, (n % 2 == 0) ? 32'd2 : 32'd1);
      if (n == 3) begin
        if_req = 1'b0; dm_req = 1'b0;
      end else begin
        if (dm_ack) dm_req = 1'b0;
        if (if_ack) if_req = 1'b0;
        @(negedge clk);
        if_req = 1'b1; dm_req = 1'b1;
      end
    end
    repeat (2) @(negedge clk);
    chk("contention_idle", 32'(busy), 32'd0);

    // Reset during the write cycle aborts it; the held request is reissued.
    sb1.push_back('{dm: 1'b1, data: 32'h0, mis: 1'b0});
    dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h12345678; dm_req = 1'b1;
    @(negedge clk);
    chk("rstwr_we_before", 32'(WE), 32'd1);
    chk("rstwr_adr", 32'(Adr), 32'h20);
    #1 rst_n = 1'b0;
    #1 chk("rstwr_we_async", 32'(WE), 32'd0);
    chk("rstwr_busy_async", 32'(busy), 32'd0);
    @(negedge clk);
    chk("rstwr_no_ack", {30'b0, dm_ack, if_ack}, 32'd0);
    chk("rstwr_rdata_cleared", if_rdata | dm_rdata, 32'd0);
    rst_n = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!dm_ack && cyc < 20);
    dm_req = 1'b0;
    chk("rstwr_reissue_latency", cyc, 32'd2);
    @(negedge clk);
    chk("rstwr_mem", mem1[8'h20], 32'h12345678);

    // READ_LAT=3 with a wrapping address: 0x404 maps to word 1.
    sb3.push_back('{dm: 1'b0, data: 32'hCAFE0001, mis: 1'b0});
    if_addr3 = 32'h404; if_req3 = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("lat3_c1_adr", 32'(Adr3), 32'd1);
    end while (!if_ack3 && cyc < 20);
    if_req3 = 1'b0;
    chk("lat3_latency", cyc, 32'd4);
    @(negedge clk);
    chk("lat3_idle_busy", 32'(busy3), 32'd0);

    repeat (2) @(negedge clk);
    chk("sb1_drained", sb1.size(), 32'd0);
    chk("sb3_drained", sb3.size(), 32'd0);
    chk("dut3_untouched", dm_rdata3 | WD3, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
